// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the AXI4-Lite request arbiter.
package axil_arb_pkg;

  // Transaction sequencer states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    ACK     = 3'd5
  } state_t;

  // AXI response codes.
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Fixed sideband values: full-word writes, unprivileged secure data access.
  localparam logic [3:0] WSTRB_ALL    = 4'hF;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first set request strictly
// after the pointer, wrapping around.
module rr_arbiter
  import axil_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Scan candidates pointer+1 .. pointer+NUM_REQ (mod NUM_REQ); first hit wins.
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    cand  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(pointer) + off) % NUM_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        index       = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axil_req_arbiter.sv
// Round-robin arbiter serialising single-word read/write commands from
// NUM_REQ requesters into single-beat AXI4-Lite transactions, one at a time.
//
// Handshake rules: on the AXI side a transfer happens on a rising edge where
// VALID and READY are both high; every VALID this block raises is held until
// that edge and dropped in the following cycle. On the requester side req is a
// level held with its fields until the one-cycle ack pulse; ack_rdata/ack_resp
// are meaningful only while ack is high.
module axil_req_arbiter
  import axil_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             ack,
  output logic [DATA_WIDTH-1:0]          ack_rdata,
  output logic [1:0]                     ack_resp,
  output logic                           busy,
  output logic [ADDR_WIDTH-1:0]          M_AXI_AWADDR,
  output logic [2:0]                     M_AXI_AWPROT,
  output logic                           M_AXI_AWVALID,
  input  logic                           M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]          M_AXI_WDATA,
  output logic [3:0]                     M_AXI_WSTRB,
  output logic                           M_AXI_WVALID,
  input  logic                           M_AXI_WREADY,
  input  logic [1:0]                     M_AXI_BRESP,
  input  logic                           M_AXI_BVALID,
  output logic                           M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]          M_AXI_ARADDR,
  output logic [2:0]                     M_AXI_ARPROT,
  output logic                           M_AXI_ARVALID,
  input  logic                           M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]          M_AXI_RDATA,
  input  logic [1:0]                     M_AXI_RRESP,
  input  logic                           M_AXI_RVALID,
  output logic                           M_AXI_RREADY
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;

  logic [NUM_REQ-1:0]      arb_grant;
  logic [IDX_W-1:0]        arb_index;
  logic                    arb_any;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req     (req),
    .pointer (ptr_q),
    .grant   (arb_grant),
    .index   (arb_index),
    .any     (arb_any)
  );

  // Pick the command fields of the requester the picker selected.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state and next-output logic; every AXI output is produced as a
  // register next-value so no AXI input reaches an AXI output combinationally.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    ack_d     = '0;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_index;
          ptr_d   = arb_index;
          addr_d  = sel_addr & ~ADDR_WIDTH'(3);  // word-aligned only
          wdata_d = sel_wdata;
          if (sel_we) begin
            state_d   = WR_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_AW_W: begin
        // AW and W retire independently, in either order.
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_B;
          bready_d = 1'b1;
        end
      end
      WR_B: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          resp_d   = M_AXI_BRESP;
          ack_d    = NUM_REQ'(1) << grant_q;
          state_d  = ACK;
        end
      end
      RD_AR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (M_AXI_RVALID) begin
          rready_d = 1'b0;
          rdata_d  = M_AXI_RDATA;
          resp_d   = M_AXI_RRESP;
          ack_d    = NUM_REQ'(1) << grant_q;
          state_d  = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset is immediate, even mid-transaction.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      grant_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= OKAY;
      ack_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      ack_q     <= ack_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign ack           = ack_q;
  assign ack_rdata     = rdata_q;
  assign ack_resp      = resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = WSTRB_ALL;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = PROT_DEFAULT;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Bench for axil_req_arbiter: AXI4-Lite slave model with wait-state and error
// injection, requester drivers, a register-file reference model feeding an
// expected-ack queue, and an independent ack monitor.
module tb_axil_req_arbiter;

  localparam int NUM_REQ = 2;
  localparam int AW      = 4;
  localparam int DW      = 32;
  localparam int EXP_W   = NUM_REQ + 2 + DW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [NUM_REQ-1:0]    req       = '0;
  logic [NUM_REQ-1:0]    req_we    = '0;
  logic [NUM_REQ*AW-1:0] req_addr  = '0;
  logic [NUM_REQ*DW-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]    ack;
  logic [DW-1:0]         ack_rdata;
  logic [1:0]            ack_resp;
  logic                  busy;
  logic [AW-1:0]         awaddr, araddr;
  logic [2:0]            awprot, arprot;
  logic                  awvalid, wvalid, bready, arvalid, rready;
  logic [DW-1:0]         wdata;
  logic [3:0]            wstrb;
  logic                  awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic                  arready = 1'b0, rvalid = 1'b0;
  logic [1:0]            bresp = 2'b00, rresp = 2'b00;
  logic [DW-1:0]         rdata = '0;

  axil_req_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack), .ack_rdata(ack_rdata), .ack_resp(ack_resp), .busy(busy),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int ack_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] model_mem[4];
  logic [DW-1:0] model_last_rdata = '0;
  int            model_last_grant = NUM_REQ - 1;
  bit            err_on_8 = 1'b0;

  // Apply one command to the register-file model and queue the ack it must produce.
  function automatic void predict(input int idx, input bit we, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] data);
    logic [1:0]         resp;
    logic [NUM_REQ-1:0] vec;
    resp = 2'b00;
    if (we) begin
      model_mem[addr[3:2]] = data;
    end else begin
      model_last_rdata = model_mem[addr[3:2]];
      if (err_on_8 && addr[3:2] == 2'd2) resp = 2'b10;
    end
    vec = '0;
    vec[idx] = 1'b1;
    exp_q.push_back({vec, resp, model_last_rdata});
    model_last_grant = idx;
  endfunction

  // ---------------- AXI4-Lite slave model ----------------
  logic [DW-1:0] slave_mem[4];
  int  aw_delay = 0, w_delay = 0, ar_delay = 0;
  bit  b_hold = 1'b0;
  int  cnt_awv = 0, cnt_wv = 0, cnt_bhs = 0, n_proto_err = 0;

  initial begin
    bit aw_pend, aw_got, w_pend, w_got, b_pend, ar_pend, ar_got, r_pend;
    int aw_cnt, w_cnt, ar_cnt;
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [DW-1:0] s_wdata;
    {aw_pend, aw_got, w_pend, w_got, b_pend, ar_pend, ar_got, r_pend} = '0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {aw_pend, aw_got, w_pend, w_got, b_pend, ar_pend, ar_got, r_pend} = '0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      end else begin
        if (awvalid) cnt_awv++;
        if (wvalid)  cnt_wv++;
        // retire handshakes that happened on the edge just passed
        if (aw_pend) begin aw_pend = 0; aw_got = 1; end
        if (w_pend)  begin w_pend = 0;  w_got = 1;  end
        if (b_pend)  begin b_pend = 0; bvalid = 0; aw_got = 0; w_got = 0; end
        if (ar_pend) begin ar_pend = 0; ar_got = 1; end
        if (r_pend)  begin r_pend = 0; rvalid = 0; ar_got = 0; end
        // write address
        awready = 0;
        if (awvalid && !aw_got) begin
          if (aw_cnt < aw_delay) aw_cnt++;
          else begin
            awready = 1; aw_pend = 1; aw_cnt = 0; s_awaddr = awaddr;
            if (awaddr[1:0] != 2'b00 || awprot != 3'b000) n_proto_err++;
          end
        end
        // write data
        wready = 0;
        if (wvalid && !w_got) begin
          if (w_cnt < w_delay) w_cnt++;
          else begin
            wready = 1; w_pend = 1; w_cnt = 0; s_wdata = wdata;
            if (wstrb != 4'hF) n_proto_err++;
          end
        end
        // write response, only after both AW and W have been accepted
        if (!bvalid && aw_got && w_got && !b_hold) begin
          bvalid = 1; bresp = 2'b00;
          slave_mem[s_awaddr[3:2]] = s_wdata;
        end
        if (bvalid && bready) begin b_pend = 1; cnt_bhs++; end
        // read address
        arready = 0;
        if (arvalid && !ar_got) begin
          if (ar_cnt < ar_delay) ar_cnt++;
          else begin
            arready = 1; ar_pend = 1; ar_cnt = 0; s_araddr = araddr;
            if (araddr[1:0] != 2'b00 || arprot != 3'b000) n_proto_err++;
          end
        end
        // read data
        if (!rvalid && ar_got) begin
          rvalid = 1;
          rdata  = slave_mem[s_araddr[3:2]];
          rresp  = (err_on_8 && s_araddr[3:2] == 2'd2) ? 2'b10 : 2'b00;
        end
        if (rvalid && rready) r_pend = 1;
      end
    end
  end

  // ---------------- ack monitor ----------------
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && ack != '0) begin
        ack_total++;
        check("ack_onehot", 64'($onehot(ack)), 64'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 64'(ack), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("ack_vec",   64'(ack),       64'(e[EXP_W-1 -: NUM_REQ]));
          check("ack_resp",  64'(ack_resp),  64'(e[DW +: 2]));
          check("ack_rdata", 64'(ack_rdata), 64'(e[DW-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_fields(input int i, input bit we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data);
    req_we[i] = we;
    req_addr[i*AW +: AW] = addr;
    req_wdata[i*DW +: DW] = data;
  endtask

  // Issue one command from requester idx and wait (bounded) for its ack.
  task automatic do_txn(input int idx, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, output int lat, output int busy_cnt);
    int cyc;
    predict(idx, we, addr, data);
    set_fields(idx, we, addr, data);
    req[idx] = 1'b1;
    cyc = 0; busy_cnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
    end while (!ack[idx] && cyc < 200);
    if (!ack[idx]) check("ack_timeout", 64'(cyc), 64'd0);
    req[idx] = 1'b0;
    lat = cyc;
    @(negedge clk);
  endtask

  // All requesters re-request continuously, k commands each.
  task automatic run_concurrent(input int k);
    bit            c_we[NUM_REQ][16];
    logic [AW-1:0] c_addr[NUM_REQ][16];
    logic [DW-1:0] c_data[NUM_REQ][16];
    int sent[NUM_REQ];
    bit holding[NUM_REQ];
    int gap[NUM_REQ];
    int first, cyc;
    bit done;
    for (int i = 0; i < NUM_REQ; i++)
      for (int t = 0; t < k; t++) begin
        c_we[i][t]   = 1'($urandom_range(0, 1));
        c_addr[i][t] = AW'($urandom_range(0, 15));
        c_data[i][t] = $urandom;
      end
    // all pending at every decision point: service rotates from the last winner
    first = (model_last_grant + 1) % NUM_REQ;
    for (int t = 0; t < k; t++)
      for (int s = 0; s < NUM_REQ; s++) begin
        int r;
        r = (first + s) % NUM_REQ;
        predict(r, c_we[r][t], c_addr[r][t], c_data[r][t]);
      end
    for (int i = 0; i < NUM_REQ; i++) begin
      set_fields(i, c_we[i][0], c_addr[i][0], c_data[i][0]);
      req[i] = 1'b1; holding[i] = 1'b1; sent[i] = 1; gap[i] = 0;
    end
    cyc = 0; done = 1'b0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (holding[i] && ack[i]) begin
          req[i] = 1'b0; holding[i] = 1'b0; gap[i] = 1;
        end else if (!holding[i] && gap[i] > 0) begin
          gap[i]--;
        end else if (!holding[i] && sent[i] < k) begin
          set_fields(i, c_we[i][sent[i]], c_addr[i][sent[i]], c_data[i][sent[i]]);
          req[i] = 1'b1; holding[i] = 1'b1; sent[i]++;
        end
      end
      done = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) if (holding[i] || sent[i] < k) done = 1'b0;
    end
    check("concurrent_done", 64'(done), 64'd1);
    req = '0;
    @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, bc, awv0, wv0, bhs0, ack0, cyc;
    for (int i = 0; i < 4; i++) begin
      slave_mem[i] = $urandom;
      model_mem[i] = slave_mem[i];
    end
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'({awvalid, wvalid, bready, arvalid, rready, ack, busy}), 64'd0);
    check("rst_rdata", 64'(ack_rdata), 64'd0);
    check("rst_resp",  64'(ack_resp),  64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed write then read-back through requester 0
    for (int i = 0; i < 4; i++) do_txn(0, 1'b1, AW'(i * 4), DW'(i + 1), lat, bc);
    for (int i = 0; i < 4; i++) do_txn(0, 1'b0, AW'(i * 4), '0, lat, bc);

    // zero-wait read latency and busy span
    check("busy_idle", 64'(busy), 64'd0);
    do_txn(1, 1'b0, 4'h0, '0, lat, bc);
    check("read_latency", 64'(lat), 64'd3);
    check("read_busy_cycles", 64'(bc), 64'd3);
    do_txn(1, 1'b1, 4'hC, 32'h1234_5678, lat, bc);
    check("write_latency", 64'(lat), 64'd3);

    // AWREADY held off three cycles while WREADY is immediate
    aw_delay = 3; w_delay = 0;
    awv0 = cnt_awv; wv0 = cnt_wv; bhs0 = cnt_bhs; ack0 = ack_total;
    do_txn(0, 1'b1, 4'h4, 32'hA5A5_0004, lat, bc);
    check("aw_delay_awvalid_cycles", 64'(cnt_awv - awv0), 64'd4);
    check("aw_delay_wvalid_cycles",  64'(cnt_wv - wv0),   64'd1);
    check("aw_delay_b_handshakes",   64'(cnt_bhs - bhs0), 64'd1);
    check("aw_delay_acks",           64'(ack_total - ack0), 64'd1);
    aw_delay = 0;

    // slave error on 0x8, then a normal read
    err_on_8 = 1'b1;
    do_txn(0, 1'b0, 4'h8, '0, lat, bc);
    do_txn(0, 1'b0, 4'h4, '0, lat, bc);
    err_on_8 = 1'b0;

    // simultaneous continuous requesters; last winner was 0 so 1 goes first
    run_concurrent(4);

    // randomized single commands with random wait states and error injection
    for (int n = 0; n < 30; n++) begin
      aw_delay = $urandom_range(0, 3);
      w_delay  = $urandom_range(0, 3);
      ar_delay = $urandom_range(0, 3);
      err_on_8 = 1'($urandom_range(0, 1));
      do_txn($urandom_range(0, NUM_REQ - 1), 1'($urandom_range(0, 1)),
             AW'($urandom_range(0, 15)), $urandom, lat, bc);
    end
    aw_delay = 0; w_delay = 0; ar_delay = 0; err_on_8 = 1'b0;
    run_concurrent(3);

    // reset in the middle of a write waiting for B
    b_hold = 1'b1;
    set_fields(0, 1'b1, 4'h4, 32'hDEAD_BEEF);
    req[0] = 1'b1;
    cyc = 0;
    while (!bready && cyc < 100) begin @(negedge clk); cyc++; end
    check("reached_wr_b", 64'(bready), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", 64'({awvalid, wvalid, bready, arvalid, rready, ack, busy}), 64'd0);
    check("midrst_rdata", 64'(ack_rdata), 64'd0);
    check("midrst_resp",  64'(ack_resp),  64'd0);
    req = '0;
    b_hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_last_grant = NUM_REQ - 1;
    model_last_rdata = '0;
    @(negedge clk);
    run_concurrent(2);

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("axi_protocol_fields", 64'(n_proto_err), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_req_arbiter.md
Name: axil_req_arbiter

Overview:
- Round-robin arbiter that shares one AXI4-Lite register-bank slave (the 4 x 32-bit test_ports register set) between NUM_REQ simple requesters.
- Each requester issues single-word read/write commands over a req/ack interface.
- The block serialises them into single-beat AXI4-Lite transactions, one outstanding at a time.
- It sits between firmware-side/sequencer logic and the slave's S00_AXI port.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 4, AXI byte-address width (4 regs x 4 bytes).
- DATA_WIDTH, 32, AXI data width; only 32 supported.

Ports:
- ACLK  in  1  clock, rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester command request; level, held until ack.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed byte addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*32  packed write data.
- ack  out  NUM_REQ  one-cycle completion pulse, one-hot.
- ack_rdata  out  32  read data, valid with ack.
- ack_resp  out  2  BRESP/RRESP of the completed transaction, valid with ack.
- busy  out  1  high whenever state != IDLE.
- M_AXI_AWADDR  out  ADDR_WIDTH  write address.
- M_AXI_AWPROT  out  3  constant 3'b000.
- M_AXI_AWVALID  out  1  write address valid.
- M_AXI_AWREADY  in  1  write address ready.
- M_AXI_WDATA  out  32  write data.
- M_AXI_WSTRB  out  4  constant 4'hF.
- M_AXI_WVALID  out  1  write data valid.
- M_AXI_WREADY  in  1  write data ready.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID  in  1  write response valid.
- M_AXI_BREADY  out  1  write response ready.
- M_AXI_ARADDR  out  ADDR_WIDTH  read address.
- M_AXI_ARPROT  out  3  constant 3'b000.
- M_AXI_ARVALID  out  1  read address valid.
- M_AXI_ARREADY  in  1  read address ready.
- M_AXI_RDATA  in  32  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RREADY  out  1  read data ready.

Behaviour:
- Reset, asynchronous and immediate, also mid-transaction:
  - All VALID/READY outputs, ack and busy go to 0.
  - ack_rdata = 0, ack_resp = 0, state = IDLE.
  - RR pointer = NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, ACK.
- IDLE: if any req bit is set, grant the first set bit strictly after the pointer (wrapping).
  - Register grant index, we, addr (bits [1:0] forced 0), wdata; update pointer to the grant.
  - Next state is WR_AW_W if we, else RD_AR.
- WR_AW_W:
  - AWVALID and WVALID assert together on entry.
  - Each deasserts on its own handshake (VALID & READY); AW and W may complete in different cycles, either order.
  - Leave for WR_B once both are done.
- WR_B: BREADY=1; on BVALID, capture BRESP and go to ACK.
- RD_AR: ARVALID=1; on ARREADY go to RD_R.
- RD_R: RREADY=1; on RVALID capture RDATA/RRESP and go to ACK.
- ACK:
  - ack[grant] = 1 for exactly one cycle; ack_rdata and ack_resp are valid this cycle.
  - ack_rdata holds its last read value after a write.
  - Next state is IDLE.
- Latency with a zero-wait slave:
  - req seen in IDLE at cycle 0.
  - VALIDs high in cycle 1.
  - B/R handshake no earlier than cycle 2.
  - ack in cycle 3.
- Requester protocol:
  - Hold req and its fields stable until ack.
  - Drop req in the cycle after ack; IDLE samples again then.
  - req dropped early is a violation: the transaction still completes and ack is still pulsed.
- Error responses (SLVERR 2'b10, DECERR 2'b11) are reported through ack_resp; no retry.
- Outputs are registered; no combinational path from AXI inputs to AXI outputs.
- Boundary cases:
  - Simultaneous requests are served in RR order.
  - A single persistent requester gets back-to-back service.
  - A new req arriving during busy waits for IDLE.

Decomposition:
- Package axil_arb_pkg holds:
  - state enum
  - response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - WSTRB_ALL=4'hF, PROT_DEFAULT=3'b000
- Sub-module rr_arbiter: NUM_REQ-wide combinational round-robin picker.
  - Inputs: req, pointer.
  - Outputs: one-hot grant, index, any.

Test Plan:
- Requester 0 writes 0x00000001..0x00000004 to addresses 0x0,0x4,0x8,0xC, then reads them back -> ack_rdata matches each value, ack_resp=2'b00 throughout.
- req=2'b11 held with both requesters continuously re-requesting -> grant order 0,1,0,1; every ack is one-hot; no starvation.
- Slave holds AWREADY low 3 cycles while WREADY=1 immediately -> WVALID drops after 1 cycle, AWVALID stays high 4 cycles, exactly one B handshake, one ack.
- Slave returns RRESP=2'b10 on read of 0x8 -> ack_resp=2'b10; next transaction proceeds normally.
- ARESETN asserted while in WR_B -> all VALID/READY, ack and busy are 0 immediately; after release, requester 0 is granted first.
- Zero-wait slave, single read -> ack exactly 3 cycles after req is sampled in IDLE; busy high for those cycles.
